// File: rtl/dram_port_arbiter.sv
// Two-port arbiter sharing the single-port data RAM between the CPU (port 0) and the debug/loader port (port 1).
// Optional build macro ARB_ROUND_ROBIN_EN replaces CPU-priority + starvation guard with round-robin contention.
module dram_port_arbiter #(
    parameter int unsigned AW       = 24,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          i_clk,
    input  logic          i_rstb,
    input  logic          i_clk_en,
    input  logic          i_cpu_req,
    input  logic          i_cpu_wr,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_din,
    output logic          o_cpu_stall,
    output logic          o_cpu_rvalid,
    input  logic          i_dbg_req,
    input  logic          i_dbg_wr,
    input  logic          i_dbg_lock,
    input  logic [AW-1:0] i_dbg_addr,
    input  logic [DW-1:0] i_dbg_din,
    output logic          o_dbg_gnt,
    output logic          o_dbg_rvalid,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_din,
    output logic          o_ram_wr,
    input  logic [DW-1:0] i_ram_dout,
    output logic [DW-1:0] o_rdata
);

    localparam int unsigned CW = 8;

    typedef enum logic {
        ST_IDLE       = 1'b0,
        ST_DBG_LOCKED = 1'b1
    } state_t;

    state_t r_state;
    logic   r_cpu_rvalid;
    logic   r_dbg_rvalid;
    logic   w_cpu_gnt;
    logic   w_dbg_gnt;
    logic   w_contend;
    logic   w_dbg_wins;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_gnt_dbg;

    assign w_dbg_wins = ~r_last_gnt_dbg;

    // Priority flips only on contended grants; reset value lets the CPU win first.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_last_gnt_dbg <= 1'b1;
        end else if (i_clk_en && w_contend && r_state == ST_IDLE) begin
            r_last_gnt_dbg <= w_dbg_gnt;
        end
    end
`else
    logic [CW-1:0] r_wait_cnt;

    assign w_dbg_wins = (r_wait_cnt == CW'(MAX_WAIT));

    // Counts consecutive denied debug cycles, saturating at the force threshold.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_wait_cnt <= '0;
        end else if (i_clk_en) begin
            if (!i_dbg_req || w_dbg_gnt) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != CW'(MAX_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
        end
    end
`endif

    assign w_contend = i_cpu_req & i_dbg_req;

    // Grant decision; nothing is granted while reset is asserted.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dbg_gnt = 1'b0;
        if (i_rstb) begin
            if (r_state == ST_DBG_LOCKED) begin
                w_dbg_gnt = i_dbg_req;
            end else if (w_contend) begin
                w_dbg_gnt = w_dbg_wins;
                w_cpu_gnt = ~w_dbg_wins;
            end else begin
                w_cpu_gnt = i_cpu_req;
                w_dbg_gnt = i_dbg_req;
            end
        end
    end

    assign o_ram_addr  = w_dbg_gnt ? i_dbg_addr : i_cpu_addr;
    assign o_ram_din   = w_dbg_gnt ? i_dbg_din  : i_cpu_din;
    assign o_ram_wr    = (w_cpu_gnt & i_cpu_wr) | (w_dbg_gnt & i_dbg_wr);
    assign o_cpu_stall = i_cpu_req & ~w_cpu_gnt;
    assign o_dbg_gnt   = w_dbg_gnt;
    assign o_rdata     = i_ram_dout;

    // Lock ownership and read-valid tags tracking the RAM's one-cycle latency.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_state      <= ST_IDLE;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
        end else if (i_clk_en) begin
            r_cpu_rvalid <= w_cpu_gnt & ~i_cpu_wr;
            r_dbg_rvalid <= w_dbg_gnt & ~i_dbg_wr;
            case (r_state)
                ST_IDLE: begin
                    if (w_dbg_gnt && i_dbg_lock) begin
                        r_state <= ST_DBG_LOCKED;
                    end
                end
                ST_DBG_LOCKED: begin
                    if (!i_dbg_lock) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cpu_rvalid = r_cpu_rvalid;
    assign o_dbg_rvalid = r_dbg_rvalid;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: vector table, directed corner sequences and randomized traffic vs a reference model.
module tb_dram_port_arbiter;

    localparam int unsigned AW       = 24;
    localparam int unsigned DW       = 32;
    localparam int unsigned MAX_WAIT = 8;

    logic          clk = 1'b0;
    logic          rstb, clk_en;
    logic          cpu_req, cpu_wr, dbg_req, dbg_wr, dbg_lock;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_din, dbg_din;
    logic          o_cpu_stall, o_cpu_rvalid, o_dbg_gnt, o_dbg_rvalid, o_ram_wr;
    logic [AW-1:0] o_ram_addr;
    logic [DW-1:0] o_ram_din, o_rdata;

    logic [DW-1:0] ram [256];
    logic [DW-1:0] ram_dout = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit            m_locked, m_dbg_turn, m_cpu_rv, m_dbg_rv;
    int            m_wait;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_mem [256];
    bit            e_cpu_gnt, e_dbg_gnt;
    logic          s_stall, s_dbg_gnt;

    typedef struct {
        logic cpu_req, cpu_wr, dbg_req, dbg_wr;
        logic exp_stall, exp_gnt, exp_wr, exp_sel_dbg;
    } vec_t;
    vec_t vecs[6];

    dram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) u_dut (
        .i_clk(clk), .i_rstb(rstb), .i_clk_en(clk_en),
        .i_cpu_req(cpu_req), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr), .i_cpu_din(cpu_din),
        .o_cpu_stall(o_cpu_stall), .o_cpu_rvalid(o_cpu_rvalid),
        .i_dbg_req(dbg_req), .i_dbg_wr(dbg_wr), .i_dbg_lock(dbg_lock),
        .i_dbg_addr(dbg_addr), .i_dbg_din(dbg_din),
        .o_dbg_gnt(o_dbg_gnt), .o_dbg_rvalid(o_dbg_rvalid),
        .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din), .o_ram_wr(o_ram_wr),
        .i_ram_dout(ram_dout), .o_rdata(o_rdata)
    );

    always #5 clk = ~clk;

    // Bench RAM: registered read, shares the clock enable
    always @(posedge clk) begin
        if (clk_en) begin
            if (o_ram_wr) ram[o_ram_addr[7:0]] <= o_ram_din;
            ram_dout <= ram[o_ram_addr[7:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_dbg_turn = 0; m_cpu_rv = 0; m_dbg_rv = 0; m_wait = 0;
    endtask

    task automatic predict();
        bit dbg_first;
        e_cpu_gnt = 0; e_dbg_gnt = 0;
        if (rstb) begin
            if (m_locked) begin
                e_dbg_gnt = dbg_req;
            end else if (cpu_req && dbg_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                dbg_first = m_dbg_turn;
`else
                dbg_first = (m_wait >= int'(MAX_WAIT));
`endif
                e_dbg_gnt = dbg_first;
                e_cpu_gnt = !dbg_first;
            end else begin
                e_cpu_gnt = cpu_req;
                e_dbg_gnt = dbg_req;
            end
        end
    endtask

    task automatic model_update();
        if (!rstb) begin
            model_reset();
        end else if (clk_en) begin
            m_cpu_rv = e_cpu_gnt && !cpu_wr;
            m_dbg_rv = e_dbg_gnt && !dbg_wr;
            if (m_cpu_rv) m_rdata = m_mem[cpu_addr[7:0]];
            if (m_dbg_rv) m_rdata = m_mem[dbg_addr[7:0]];
            if (e_cpu_gnt && cpu_wr) m_mem[cpu_addr[7:0]] = cpu_din;
            if (e_dbg_gnt && dbg_wr) m_mem[dbg_addr[7:0]] = dbg_din;
            if (dbg_req && !e_dbg_gnt) m_wait = (m_wait + 1 > int'(MAX_WAIT)) ? int'(MAX_WAIT) : m_wait + 1;
            else m_wait = 0;
            if (cpu_req && dbg_req && !m_locked) m_dbg_turn = e_cpu_gnt;
            m_locked = m_locked ? bit'(dbg_lock) : (e_dbg_gnt && dbg_lock);
        end
    endtask

    // One clock: predict, check mid-cycle, advance, update model
    task automatic cycle();
        predict();
        @(negedge clk);
        s_stall   = o_cpu_stall;
        s_dbg_gnt = o_dbg_gnt;
        chk("cpu_stall", 32'(o_cpu_stall), 32'(cpu_req && !e_cpu_gnt));
        chk("dbg_gnt", 32'(o_dbg_gnt), 32'(e_dbg_gnt));
        chk("ram_wr", 32'(o_ram_wr), 32'((e_cpu_gnt && cpu_wr) || (e_dbg_gnt && dbg_wr)));
        chk("ram_addr", 32'(o_ram_addr), 32'(e_dbg_gnt ? dbg_addr : cpu_addr));
        if (e_cpu_gnt || e_dbg_gnt) chk("ram_din", o_ram_din, e_dbg_gnt ? dbg_din : cpu_din);
        chk("cpu_rvalid", 32'(o_cpu_rvalid), 32'(m_cpu_rv));
        chk("dbg_rvalid", 32'(o_dbg_rvalid), 32'(m_dbg_rv));
        if (m_cpu_rv || m_dbg_rv) chk("rdata", o_rdata, m_rdata);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_all();
        cpu_req = 0; cpu_wr = 0; dbg_req = 0; dbg_wr = 0; dbg_lock = 0;
    endtask

    initial begin
        bit cpu_pend, dbg_pend;
        int first_gnt;
        for (int i = 0; i < 256; i++) begin ram[i] = '0; m_mem[i] = '0; end
        m_rdata = '0;
        vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{1, 1, 0, 0, 0, 0, 1, 0};
        vecs[2] = '{1, 0, 0, 0, 0, 0, 0, 0};
        vecs[3] = '{0, 0, 1, 1, 0, 1, 1, 1};
        vecs[4] = '{0, 0, 1, 0, 0, 1, 0, 1};
        vecs[5] = '{1, 0, 1, 1, 0, 0, 0, 0};

        rstb = 0; clk_en = 1; idle_all();
        cpu_addr = 24'h000111; dbg_addr = 24'h000222; cpu_din = 32'hA5A5_0001; dbg_din = 32'h5A5A_0002;
        model_reset();
        #2;
        cpu_req = 1; cpu_wr = 1; dbg_req = 1; dbg_wr = 1;
        cycle();
        chk("reset_stall", 32'(s_stall), 32'd1);
        chk("reset_rvalid", 32'({o_cpu_rvalid, o_dbg_rvalid}), 32'd0);
        rstb = 1;

        // Vector table with clk_en low: grants are combinational, no state moves
        clk_en = 0;
        foreach (vecs[i]) begin
            cpu_req = vecs[i].cpu_req; cpu_wr = vecs[i].cpu_wr;
            dbg_req = vecs[i].dbg_req; dbg_wr = vecs[i].dbg_wr;
            #3;
            chk($sformatf("vec%0d_stall", i), 32'(o_cpu_stall), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_gnt", i), 32'(o_dbg_gnt), 32'(vecs[i].exp_gnt));
            chk($sformatf("vec%0d_wr", i), 32'(o_ram_wr), 32'(vecs[i].exp_wr));
            chk($sformatf("vec%0d_addr", i), 32'(o_ram_addr),
                vecs[i].exp_sel_dbg ? 32'h000222 : 32'h000111);
        end
        @(posedge clk); #1;
        clk_en = 1;

        // Continuous contention from a fresh reset
        cpu_req = 1; cpu_wr = 0; cpu_addr = 24'h1; dbg_req = 1; dbg_wr = 0; dbg_addr = 24'h2;
        for (int i = 0; i < 27; i++) begin
            cycle();
`ifdef ARB_ROUND_ROBIN_EN
            chk($sformatf("contend_gnt%0d", i), 32'(s_dbg_gnt), 32'(i % 2 == 1));
`else
            chk($sformatf("contend_gnt%0d", i), 32'(s_dbg_gnt), 32'(i % 9 == 8));
`endif
            chk($sformatf("contend_stall%0d", i), 32'(s_stall), 32'(s_dbg_gnt));
        end
        idle_all(); cycle();

        // CPU-only write then read
        cpu_req = 1; cpu_wr = 1; cpu_addr = 24'h000010; cpu_din = 32'h1234_5678;
        cycle();
        chk("cpu_wr_stall", 32'(s_stall), 32'd0);
        cpu_wr = 0;
        cycle();
        chk("cpu_rd_stall", 32'(s_stall), 32'd0);
        idle_all();
        #3;
        chk("cpu_rvalid_after_rd", 32'(o_cpu_rvalid), 32'd1);
        chk("cpu_rdata", o_rdata, 32'h1234_5678);
        chk("dbg_rvalid_cpu_only", 32'(o_dbg_rvalid), 32'd0);
        cycle();

        // Debug lock: 4 writes, 2 idle with lock held, then lock dropped
        dbg_req = 1; dbg_wr = 1; dbg_lock = 1; dbg_addr = 24'h20; dbg_din = 32'hD0D0_0000;
        cycle();
        cpu_req = 1; cpu_wr = 0; cpu_addr = 24'h3;
        for (int i = 1; i < 4; i++) begin
            dbg_addr = 24'(32'h20 + i); dbg_din = 32'hD0D0_0000 + i;
            cycle();
            chk($sformatf("lock_wr_stall%0d", i), 32'(s_stall), 32'd1);
        end
        dbg_req = 0; dbg_wr = 0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk($sformatf("lock_idle_stall%0d", i), 32'(s_stall), 32'd1);
        end
        dbg_lock = 0;
        cycle();
        chk("lock_drop_stall", 32'(s_stall), 32'd1);
        cycle();
        chk("after_lock_stall", 32'(s_stall), 32'd0);
        idle_all(); cycle();

`ifndef ARB_ROUND_ROBIN_EN
        // Clock enable pause at wait_cnt=5 delays the force by 3 cycles
        cpu_req = 1; cpu_addr = 24'h4; dbg_req = 1; dbg_addr = 24'h5;
        first_gnt = -1;
        for (int i = 0; i < 20 && first_gnt < 0; i++) begin
            clk_en = (i >= 5 && i < 8) ? 1'b0 : 1'b1;
            cycle();
            if (s_dbg_gnt && clk_en) first_gnt = i;
        end
        clk_en = 1;
        chk("clk_en_force_cycle", 32'(first_gnt), 32'd11);
        idle_all(); cycle();
`endif

        // Reset in the middle of a locked burst with a read in flight
        dbg_req = 1; dbg_wr = 0; dbg_lock = 1; dbg_addr = 24'h21;
        cycle();
        dbg_wr = 1; dbg_din = 32'hBEEF_0001; cpu_req = 1; cpu_wr = 0;
        #2;
        chk("pre_reset_ram_wr", 32'(o_ram_wr), 32'd1);
        chk("pre_reset_dbg_rvalid", 32'(o_dbg_rvalid), 32'd1);
        rstb = 0;
        #1;
        model_reset();
        chk("reset_ram_wr", 32'(o_ram_wr), 32'd0);
        chk("reset_rvalids", 32'({o_cpu_rvalid, o_dbg_rvalid}), 32'd0);
        cycle();
        rstb = 1; dbg_req = 0; dbg_wr = 0; dbg_lock = 0;
        cycle();
        chk("post_reset_cpu_stall", 32'(s_stall), 32'd0);
        idle_all(); cycle();

        // Randomized traffic; an ungranted requester holds its request
        cpu_pend = 0; dbg_pend = 0;
        for (int n = 0; n < 400; n++) begin
            clk_en = ($urandom_range(0, 4) != 0);
            if (!cpu_pend) begin
                cpu_req = ($urandom_range(0, 2) != 0); cpu_wr = 1'($urandom);
                cpu_addr = 24'($urandom_range(0, 15)); cpu_din = $urandom;
            end
            if (!dbg_pend) begin
                dbg_req = ($urandom_range(0, 1) != 0); dbg_wr = 1'($urandom);
                dbg_addr = 24'($urandom_range(0, 15)); dbg_din = $urandom;
            end
            dbg_lock = ($urandom_range(0, 2) == 0);
            cycle();
            cpu_pend = cpu_req && !(e_cpu_gnt && clk_en);
            dbg_pend = dbg_req && !(e_dbg_gnt && clk_en);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the CPU data port (requester 0) and a debug/loader port (requester 1, used for RAM preload, inspection and dump).
- Sits in the system between the CPU data bus and the data RAM.
- The default scheme is CPU-priority arbitration with a starvation guard for the debug port. It supports a debug lock for atomic bursts and returns tagged read-valid strobes that track the RAM's one-cycle read latency.

Parameters:
- AW, 24, address width (matches CPU data address)
- DW, 32, data width
- MAX_WAIT, 8, number of consecutive denied debug-request cycles before the debug port is forced a grant (range 1..255)

Ports:
- i_clk  in  1  system clock
- i_rstb  in  1  asynchronous active-low reset
- i_clk_en  in  1  clock enable; all state holds when low
- i_cpu_req  in  1  CPU access request
- i_cpu_wr  in  1  CPU write (1) / read (0)
- i_cpu_addr  in  AW  CPU address
- i_cpu_din  in  DW  CPU write data
- o_cpu_stall  out  1  CPU request not granted this cycle
- o_cpu_rvalid  out  1  read data for CPU valid on o_rdata
- i_dbg_req  in  1  debug access request
- i_dbg_wr  in  1  debug write / read
- i_dbg_lock  in  1  hold ownership after the current grant
- i_dbg_addr  in  AW  debug address
- i_dbg_din  in  DW  debug write data
- o_dbg_gnt  out  1  debug request accepted this cycle
- o_dbg_rvalid  out  1  read data for debug valid on o_rdata
- o_ram_addr  out  AW  RAM address
- o_ram_din  out  DW  RAM write data
- o_ram_wr  out  1  RAM write strobe
- i_ram_dout  in  DW  RAM read data (registered, 1-cycle latency)
- o_rdata  out  DW  read data; equals i_ram_dout

Behaviour:
- Decided interface: one clock, i_clk; asynchronous active-low reset, i_rstb.
- Reset values: state=IDLE; wait_cnt=0; o_cpu_rvalid=0; o_dbg_rvalid=0.
- Combinational outputs during reset: o_ram_wr=0, o_dbg_gnt=0, o_cpu_stall=i_cpu_req.
- States:
  - IDLE: no lock held.
  - DBG_LOCKED: debug owns the RAM until i_dbg_lock deasserts.
- Grant rules (combinational, evaluated every cycle):
  - IDLE, only one requester: that requester is granted.
  - IDLE, both requesting: CPU is granted unless wait_cnt==MAX_WAIT, in which case debug is granted.
  - DBG_LOCKED: debug is always granted when requesting. The CPU is stalled even if debug is idle that cycle.
- RAM mux:
  - o_ram_addr, o_ram_din and o_ram_wr are driven from the granted requester.
  - o_ram_wr = granted & wr.
  - With no grant: o_ram_wr=0 and the address holds the CPU value.
- o_cpu_stall = i_cpu_req & ~cpu_granted. o_dbg_gnt = debug granted.
- wait_cnt (updates on i_clk_en):
  - Increments when debug requests and is denied.
  - Resets to 0 on a debug grant or when debug stops requesting.
  - Saturates at MAX_WAIT.
- State transitions (on i_clk_en):
  - IDLE -> DBG_LOCKED when debug is granted with i_dbg_lock=1.
  - DBG_LOCKED -> IDLE on any cycle with i_dbg_lock=0. The grant that cycle still goes to debug if it requests.
- Read return:
  - o_cpu_rvalid / o_dbg_rvalid are registered, one cycle after a granted read for the respective port (gated by i_clk_en).
  - They never assert together. Writes produce no rvalid.
- i_clk_en low: no state or counter updates and rvalid outputs hold. Combinational grants still follow inputs.
- Reset mid-lock: returns to IDLE and the in-flight rvalid is dropped.
- Requests are level-sensitive. An ungranted requester must hold its address, data and wr stable until granted.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - IDLE contention is resolved round-robin: a last_gnt flip-flop (reset to debug, so the CPU wins first) alternates priority on each contended grant.
  - wait_cnt and MAX_WAIT are unused; the parameter remains for compatibility.
  - Lock behaviour is unchanged.
- Undefined: CPU-priority with the starvation guard, as above.

Test Plan:
- CPU-only traffic: CPU writes 0x12345678 to 0x000010, then reads 0x000010.
  - Expect o_cpu_stall=0 throughout.
  - o_cpu_rvalid=1 one cycle after the read with o_rdata=0x12345678; o_dbg_rvalid=0.
- Continuous contention, MAX_WAIT=8: both ports request every cycle.
  - Debug is denied for 8 cycles and granted on the 9th; the CPU is stalled exactly on that cycle.
  - The pattern repeats with a period of 9.
- Debug lock: debug is granted with i_dbg_lock=1 for 4 writes, then idles 2 cycles with the lock held, then drops the lock.
  - o_cpu_stall=1 for all 6 locked cycles.
  - The CPU is granted in the cycle after the lock drops.
- Reset mid-lock: assert i_rstb=0 asynchronously while in DBG_LOCKED with a read in flight.
  - Immediately: o_ram_wr=0 and both rvalid outputs are 0.
  - After release: CPU-only requests are granted at once.
- Clock enable: hold i_clk_en=0 for 3 cycles during contention with wait_cnt=5.
  - wait_cnt stays at 5; the debug force occurs 3 cycles later than with i_clk_en=1.
- ARB_ROUND_ROBIN_EN defined, continuous contention:
  - Grants alternate CPU, debug, CPU, debug starting with the CPU.
  - Each rvalid is tagged to the correct port.
